// File: rtl/alarm_time_setter.sv
// Pushbutton front end for the alarm clock core: debounces the buttons, edits the alarm hour/minute
// through an IDLE/SET_H/SET_M FSM with auto-repeat and edit timeout, and snoozes or dismisses a ringing alarm.
module alarm_time_setter #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_RATE     = 2,
  parameter int TIMEOUT         = 64,
  parameter int SNOOZE_MIN      = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_snooze,
  input  logic       alarm_in,
  output logic [4:0] alarm_hours,
  output logic [5:0] alarm_minutes,
  output logic       alarm_armed,
  output logic [1:0] edit_mode,
  output logic       alarm_ack
);

  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } state_t;

  // Button bit order: 0 mode, 1 up, 2 down, 3 snooze
  logic [3:0]         raw;
  logic [3:0]         sync1_q, sync2_q;
  logic [3:0]         deb_q, deb_d, deb_prev_q;
  logic [3:0][DW-1:0] db_cnt_q, db_cnt_d;
  logic [3:0]         press;

  logic [1:0][RW-1:0] rep_cnt_q, rep_cnt_d;
  logic [1:0]         rep_first_q, rep_first_d;
  logic [1:0]         rep_fire;

  state_t      state_q, state_d;
  logic [4:0]  com_h_q, com_h_d, shad_h_q, shad_h_d;
  logic [5:0]  com_m_q, com_m_d, shad_m_q, shad_m_d;
  logic        armed_q, armed_d;
  logic        ack_q, ack_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic        editing, up_ev, dn_ev, any_ev, timeout;
  logic [6:0]  snz_sum;

  function automatic logic [4:0] hr_step(input logic [4:0] h, input logic up);
    if (up) return (h == 5'd23) ? 5'd0 : h + 5'd1;
    else    return (h == 5'd0) ? 5'd23 : h - 5'd1;
  endfunction

  function automatic logic [5:0] min_step(input logic [5:0] m, input logic up);
    if (up) return (m == 6'd59) ? 6'd0 : m + 6'd1;
    else    return (m == 6'd0) ? 6'd59 : m - 6'd1;
  endfunction

  assign raw     = {btn_snooze, btn_down, btn_up, btn_mode};
  assign press   = deb_q & ~deb_prev_q;
  assign editing = (state_q != IDLE);

  // Counter restarts whenever the synced level agrees with the accepted level.
  always_comb begin
    deb_d    = deb_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d[i]    = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_first_d = rep_first_q;
    rep_fire    = 2'b00;
    for (int j = 0; j < 2; j++) begin
      if (!editing || !deb_q[j+1]) begin
        rep_cnt_d[j]   = '0;
        rep_first_d[j] = 1'b0;
      end else if (press[j+1]) begin
        rep_cnt_d[j]   = RW'(1);
        rep_first_d[j] = 1'b0;
      end else if ((!rep_first_q[j] && rep_cnt_q[j] == RW'(REPEAT_DELAY)) ||
                   ( rep_first_q[j] && rep_cnt_q[j] == RW'(REPEAT_RATE))) begin
        rep_fire[j]    = 1'b1;
        rep_cnt_d[j]   = RW'(1);
        rep_first_d[j] = 1'b1;
      end else begin
        rep_cnt_d[j] = rep_cnt_q[j] + 1'b1;
      end
    end
  end

  assign up_ev   = press[1] | rep_fire[0];
  assign dn_ev   = press[2] | rep_fire[1];
  assign any_ev  = (|press) | (|rep_fire);
  assign timeout = editing && !any_ev && (tmo_q == TW'(TIMEOUT - 1));
  assign snz_sum = {1'b0, com_m_q} + 7'(SNOOZE_MIN);

  always_comb begin
    state_d  = state_q;
    com_h_d  = com_h_q;
    com_m_d  = com_m_q;
    shad_h_d = shad_h_q;
    shad_m_d = shad_m_q;
    armed_d  = armed_q;
    ack_d    = 1'b0;
    tmo_d    = '0;
    if (editing && !any_ev && !timeout) tmo_d = tmo_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (alarm_in && press[3]) begin
          ack_d = 1'b1;
          if (snz_sum >= 7'd60) begin
            com_m_d = 6'(snz_sum - 7'd60);
            com_h_d = hr_step(com_h_q, 1'b1);
          end else begin
            com_m_d = snz_sum[5:0];
          end
        end else if (press[0]) begin
          if (alarm_in) begin
            ack_d = 1'b1;
          end else begin
            state_d  = SET_H;
            shad_h_d = com_h_q;
            shad_m_d = com_m_q;
          end
        end
        if (press[1]) armed_d = ~armed_q;
      end
      SET_H: begin
        if (timeout)                state_d  = IDLE;
        else if (press[0])          state_d  = SET_M;
        else if (up_ev ^ dn_ev)     shad_h_d = hr_step(shad_h_q, up_ev);
      end
      SET_M: begin
        if (timeout) begin
          state_d = IDLE;
        end else if (press[0]) begin
          state_d = IDLE;
          com_h_d = shad_h_q;
          com_m_d = shad_m_q;
          armed_d = 1'b1;
        end else if (up_ev ^ dn_ev) begin
          shad_m_d = min_step(shad_m_q, up_ev);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      deb_q       <= '0;
      deb_prev_q  <= '0;
      db_cnt_q    <= '0;
      rep_cnt_q   <= '0;
      rep_first_q <= '0;
      state_q     <= IDLE;
      com_h_q     <= '0;
      com_m_q     <= '0;
      shad_h_q    <= '0;
      shad_m_q    <= '0;
      armed_q     <= 1'b0;
      ack_q       <= 1'b0;
      tmo_q       <= '0;
    end else if (ena) begin
      sync1_q     <= raw;
      sync2_q     <= sync1_q;
      deb_q       <= deb_d;
      deb_prev_q  <= deb_q;
      db_cnt_q    <= db_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_first_q <= rep_first_d;
      state_q     <= state_d;
      com_h_q     <= com_h_d;
      com_m_q     <= com_m_d;
      shad_h_q    <= shad_h_d;
      shad_m_q    <= shad_m_d;
      armed_q     <= armed_d;
      ack_q       <= ack_d;
      tmo_q       <= tmo_d;
    end
  end

  // While editing the outputs show the shadow copy and the core must not match against it.
  assign alarm_hours   = editing ? shad_h_q : com_h_q;
  assign alarm_minutes = editing ? shad_m_q : com_m_q;
  assign alarm_armed   = armed_q & ~editing;
  assign edit_mode     = state_q;
  assign alarm_ack     = ack_q & ena;

endmodule

// File: tb/tb_alarm_time_setter.sv
// Directed bench for alarm_time_setter: editing, wrap, debounce, auto-repeat, snooze/dismiss, timeout, ena freeze, reset.
module tb_alarm_time_setter;
  logic       clk = 1'b0;
  logic       rst_n, ena;
  logic       btn_mode, btn_up, btn_down, btn_snooze, alarm_in;
  logic [4:0] alarm_hours;
  logic [5:0] alarm_minutes;
  logic       alarm_armed;
  logic [1:0] edit_mode;
  logic       alarm_ack;

  int checks = 0;
  int errors = 0;
  int ack_n;
  logic [31:0] ack_h, ack_m;

  alarm_time_setter dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down), .btn_snooze(btn_snooze),
    .alarm_in(alarm_in),
    .alarm_hours(alarm_hours), .alarm_minutes(alarm_minutes), .alarm_armed(alarm_armed),
    .edit_mode(edit_mode), .alarm_ack(alarm_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_mode   = v;
      1: btn_up     = v;
      2: btn_down   = v;
      default: btn_snooze = v;
    endcase
  endtask

  // Clean press: 6 cycles down (shorter than the repeat delay), 8 cycles up; records alarm_ack activity.
  task automatic press(input int b);
    ack_n = 0;
    @(negedge clk);
    set_btn(b, 1'b1);
    for (int i = 0; i < 14; i++) begin
      if (i == 6) set_btn(b, 1'b0);
      @(negedge clk);
      if (alarm_ack === 1'b1) begin
        ack_n++;
        ack_h = 32'(alarm_hours);
        ack_m = 32'(alarm_minutes);
      end
    end
  endtask

  task automatic press_n(input int b, input int n);
    for (int i = 0; i < n; i++) press(b);
  endtask

  // Steps seen after k enabled edges of a held up key: press at 7, repeats from 15 every 2, six repeats total.
  function automatic int held_steps(input int k);
    int s = 0;
    int r;
    if (k >= 7) s = 1;
    if (k >= 15) begin
      r = (k - 15) / 2 + 1;
      s += (r > 6) ? 6 : r;
    end
    return s;
  endfunction

  task automatic hold_chk(input int base, input int pause_at, input string tag);
    int k = 0;
    @(negedge clk);
    btn_up = 1'b1;
    while (k < 40) begin
      if (k == pause_at) begin
        ena = 1'b0;
        for (int p = 0; p < 10; p++) begin
          @(negedge clk);
          chk({tag, "_frozen_min"}, 32'(alarm_minutes), 32'(base + held_steps(k)));
          chk({tag, "_frozen_mode"}, 32'(edit_mode), 32'd2);
        end
        ena = 1'b1;
      end
      if (k == 20) btn_up = 1'b0;
      @(negedge clk);
      k++;
      chk(tag, 32'(alarm_minutes), 32'(base + held_steps(k)));
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; alarm_in = 1'b0;
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_snooze = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hours", 32'(alarm_hours), 32'd0);
    chk("rst_minutes", 32'(alarm_minutes), 32'd0);
    chk("rst_armed", 32'(alarm_armed), 32'd0);
    chk("rst_mode", 32'(edit_mode), 32'd0);
    chk("rst_ack", 32'(alarm_ack), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Basic set sequence to 7:30
    press(0);
    chk("t1_enter_seth", 32'(edit_mode), 32'd1);
    press_n(1, 7);
    chk("t1_shadow_h7", 32'(alarm_hours), 32'd7);
    chk("t1_armed_off_edit", 32'(alarm_armed), 32'd0);
    press(0);
    chk("t1_enter_setm", 32'(edit_mode), 32'd2);
    press_n(1, 30);
    chk("t1_shadow_m30", 32'(alarm_minutes), 32'd30);
    press(0);
    chk("t1_hours", 32'(alarm_hours), 32'd7);
    chk("t1_minutes", 32'(alarm_minutes), 32'd30);
    chk("t1_armed", 32'(alarm_armed), 32'd1);
    chk("t1_idle", 32'(edit_mode), 32'd0);
    press(1);
    chk("idle_up_disarm", 32'(alarm_armed), 32'd0);
    press(1);
    chk("idle_up_rearm", 32'(alarm_armed), 32'd1);
    press(2);
    chk("idle_down_ignored", 32'(alarm_armed), 32'd1);
    chk("idle_down_time", 32'(alarm_hours), 32'd7);

    // Field wrap
    press(0);
    press_n(2, 8);
    chk("t2_h_down_wrap", 32'(alarm_hours), 32'd23);
    press(1);
    chk("t2_h_up_wrap", 32'(alarm_hours), 32'd0);
    press(2);
    chk("t2_h_back23", 32'(alarm_hours), 32'd23);
    press(0);
    press_n(2, 30);
    chk("t2_m_zero", 32'(alarm_minutes), 32'd0);
    press(2);
    chk("t2_m_down_wrap", 32'(alarm_minutes), 32'd59);
    chk("t2_no_carry", 32'(alarm_hours), 32'd23);
    press(0);
    press(0);
    press(0);
    press(2);
    chk("t2_m58", 32'(alarm_minutes), 32'd58);

    // Short glitches on up produce nothing
    for (int g = 0; g < 2; g++) begin
      @(negedge clk);
      btn_up = 1'b1;
      repeat (3) @(negedge clk);
      btn_up = 1'b0;
      repeat (10) @(negedge clk);
      chk("t3_glitch", 32'(alarm_minutes), 32'd58);
    end
    press(0);
    chk("t4_commit_h", 32'(alarm_hours), 32'd23);
    chk("t4_commit_m", 32'(alarm_minutes), 32'd58);

    // Snooze with wrap and carry, then ignored snooze, then dismiss
    alarm_in = 1'b1;
    press(3);
    chk("t4_ack_count", 32'(ack_n), 32'd1);
    chk("t4_ack_h", ack_h, 32'd0);
    chk("t4_ack_m", ack_m, 32'd3);
    chk("t4_snz_h", 32'(alarm_hours), 32'd0);
    chk("t4_snz_m", 32'(alarm_minutes), 32'd3);
    chk("t4_snz_armed", 32'(alarm_armed), 32'd1);
    alarm_in = 1'b0;
    press(3);
    chk("t4_quiet_ack", 32'(ack_n), 32'd0);
    chk("t4_quiet_m", 32'(alarm_minutes), 32'd3);
    alarm_in = 1'b1;
    press(0);
    chk("t4_dismiss_ack", 32'(ack_n), 32'd1);
    chk("t4_dismiss_idle", 32'(edit_mode), 32'd0);
    chk("t4_dismiss_m", 32'(alarm_minutes), 32'd3);
    alarm_in = 1'b0;

    // Auto-repeat, plain and with an ena pause in the middle of the hold
    press(0);
    press(0);
    press_n(1, 7);
    chk("t3_setm10", 32'(alarm_minutes), 32'd10);
    hold_chk(10, -1, "t3_hold");
    hold_chk(17, 12, "t6_hold_pause");
    press(0);
    chk("t6_commit_m", 32'(alarm_minutes), 32'd24);

    // Timeout restores the committed time and arm state
    press(0);
    press_n(1, 6);
    press(0);
    press_n(2, 24);
    press(0);
    chk("t5_start_h", 32'(alarm_hours), 32'd6);
    chk("t5_start_m", 32'(alarm_minutes), 32'd0);
    press(0);
    press_n(1, 2);
    chk("t5_shadow_h8", 32'(alarm_hours), 32'd8);
    repeat (45) @(negedge clk);
    chk("t5_before_timeout", 32'(edit_mode), 32'd1);
    repeat (30) @(negedge clk);
    chk("t5_timeout_idle", 32'(edit_mode), 32'd0);
    chk("t5_timeout_h", 32'(alarm_hours), 32'd6);
    chk("t5_timeout_m", 32'(alarm_minutes), 32'd0);
    chk("t5_timeout_armed", 32'(alarm_armed), 32'd1);

    // ena=0 stops the timeout counter
    press(0);
    repeat (30) @(negedge clk);
    ena = 1'b0;
    repeat (50) @(negedge clk);
    chk("t6_frozen_edit", 32'(edit_mode), 32'd1);
    chk("t6_frozen_ack", 32'(alarm_ack), 32'd0);
    ena = 1'b1;
    repeat (15) @(negedge clk);
    chk("t6_resume_edit", 32'(edit_mode), 32'd1);
    repeat (30) @(negedge clk);
    chk("t6_resume_timeout", 32'(edit_mode), 32'd0);

    // Reset in the middle of SET_M
    press(0);
    press(0);
    press(1);
    chk("t6_in_setm", 32'(edit_mode), 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_hours", 32'(alarm_hours), 32'd0);
    chk("t6_rst_minutes", 32'(alarm_minutes), 32'd0);
    chk("t6_rst_armed", 32'(alarm_armed), 32'd0);
    chk("t6_rst_mode", 32'(edit_mode), 32'd0);
    chk("t6_rst_ack", 32'(alarm_ack), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_after_rst_mode", 32'(edit_mode), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
